// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes, FSM states,
// the default bus timeout and the legality check applied to a MEM-stage op.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int TIMEOUT_CYCLES_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsuState_t;

    // Exactly one of read/write, a funct3 legal for that direction, natural alignment.
    function automatic logic isLegalAccess(input logic isRead, input logic isWrite,
                                           input logic [2:0] funct3, input logic [1:0] addrLo);
        logic ok;
        ok = 1'b0;
        if (isRead ^ isWrite) begin
            case (funct3)
                F3_B:    ok = 1'b1;
                F3_BU:   ok = isRead;
                F3_H:    ok = ~addrLo[0];
                F3_HU:   ok = isRead & ~addrLo[0];
                F3_W:    ok = (addrLo == 2'b00);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit.
// Handshake: mem_req rises with all fields valid and holds them stable until a
// one-cycle mem_ready completes the access; mem_ready with no request pending is ignored.
interface load_store_unit_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store data replication and byte enables, plus load
// lane extraction with sign/zero extension.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  storeFunct3,
    input  logic [1:0]  storeAddrLo,
    input  logic [31:0] storeData,
    output logic [31:0] laneData,
    output logic [3:0]  byteEn,
    input  logic [2:0]  loadFunct3,
    input  logic [1:0]  loadAddrLo,
    input  logic [31:0] loadWord,
    output logic [31:0] loadData
);

    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    always_comb begin
        laneData = '0;
        byteEn   = '0;
        case (storeFunct3)
            F3_B: begin
                laneData = {4{storeData[7:0]}};
                byteEn   = 4'b0001 << storeAddrLo;
            end
            F3_H: begin
                laneData = {2{storeData[15:0]}};
                byteEn   = storeAddrLo[1] ? 4'b1100 : 4'b0011;
            end
            F3_W: begin
                laneData = storeData;
                byteEn   = 4'b1111;
            end
            default: ;
        endcase
    end

    always_comb begin
        loadByte = '0;
        case (loadAddrLo)
            2'd0:    loadByte = loadWord[7:0];
            2'd1:    loadByte = loadWord[15:8];
            2'd2:    loadByte = loadWord[23:16];
            default: loadByte = loadWord[31:24];
        endcase
    end

    assign loadHalf = loadAddrLo[1] ? loadWord[31:16] : loadWord[15:0];

    always_comb begin
        loadData = '0;
        case (loadFunct3)
            F3_B:    loadData = {{24{loadByte[7]}}, loadByte};
            F3_BU:   loadData = {24'd0, loadByte};
            F3_H:    loadData = {{16{loadHalf[15]}}, loadHalf};
            F3_HU:   loadData = {16'd0, loadHalf};
            F3_W:    loadData = loadWord;
            default: loadData = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: stalls the pipeline around one registered bus
// access per instruction, flags illegal ops, and gives up after a timeout.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        funct3M,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    output logic              FaultM,
    output logic              BusErrM,
    load_store_unit_if.master bus,
    output lsuState_t         stateDbg
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsuState_t        state;
    lsuState_t        nextState;
    logic [CNT_W-1:0] accessCnt;

    logic        opRequested;
    logic        opLegal;
    logic        issue;
    logic        complete;
    logic        timeout;

    // Load shape is latched at issue so capture does not depend on the frozen pipeline.
    logic        isLoadQ;
    logic [2:0]  funct3Q;
    logic [1:0]  addrLoQ;

    logic [31:0] alignWdata;
    logic [3:0]  alignBe;
    logic [31:0] alignLoad;

    assign opRequested = MemReadM | MemWriteM;
    assign opLegal     = isLegalAccess(MemReadM, MemWriteM, funct3M, ALUResultM[1:0]);
    assign stateDbg    = state;

    lsu_align u_align (
        .storeFunct3 (funct3M),
        .storeAddrLo (ALUResultM[1:0]),
        .storeData   (WriteDataM),
        .laneData    (alignWdata),
        .byteEn      (alignBe),
        .loadFunct3  (funct3Q),
        .loadAddrLo  (addrLoQ),
        .loadWord    (bus.mem_rdata),
        .loadData    (alignLoad)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        StallM    = 1'b0;
        FaultM    = 1'b0;
        issue     = 1'b0;
        complete  = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (opRequested) begin
                    if (opLegal) begin
                        StallM    = 1'b1;
                        issue     = 1'b1;
                        nextState = ACCESS;
                    end else begin
                        FaultM = 1'b1;
                    end
                end
            end
            ACCESS: begin
                StallM = 1'b1;
                if (bus.mem_ready) begin
                    complete  = 1'b1;
                    nextState = DONE;
                end else if (accessCnt == CNT_LAST) begin
                    timeout   = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: begin
                // Pipeline advances at the end of this cycle; the op must not re-issue.
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ReadDataM     <= '0;
            BusErrM       <= 1'b0;
            accessCnt     <= '0;
            isLoadQ       <= 1'b0;
            funct3Q       <= '0;
            addrLoQ       <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_be    <= '0;
        end else begin
            BusErrM <= timeout;

            if (issue) begin
                accessCnt     <= '0;
                isLoadQ       <= MemReadM;
                funct3Q       <= funct3M;
                addrLoQ       <= ALUResultM[1:0];
                bus.mem_req   <= 1'b1;
                bus.mem_we    <= MemWriteM;
                bus.mem_addr  <= {ALUResultM[31:2], 2'b00};
                bus.mem_wdata <= alignWdata;
                bus.mem_be    <= alignBe;
            end else if (state == ACCESS) begin
                accessCnt <= accessCnt + 1'b1;
            end

            if (complete || timeout) begin
                bus.mem_req <= 1'b0;
            end

            if (complete && isLoadQ) begin
                ReadDataM <= alignLoad;
            end else if (FaultM || timeout) begin
                ReadDataM <= '0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, faults, timeout and
// reset during an access, with a queue of expected load results.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int TO = 4;

    logic        clk;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        FaultM;
    logic        BusErrM;
    lsuState_t   stateDbg;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .FaultM     (FaultM),
        .BusErrM    (BusErrM),
        .bus        (bus),
        .stateDbg   (stateDbg)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic dropOp();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        funct3M    = 3'b000;
        ALUResultM = '0;
        WriteDataM = '0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_rdata"}, ReadDataM, 32'h0);
        check({tag, "_stall"}, {31'd0, StallM}, 32'h0);
        check({tag, "_fault"}, {31'd0, FaultM}, 32'h0);
        check({tag, "_buserr"}, {31'd0, BusErrM}, 32'h0);
        check({tag, "_req"}, {31'd0, bus.mem_req}, 32'h0);
        check({tag, "_we"}, {31'd0, bus.mem_we}, 32'h0);
        check({tag, "_addr"}, bus.mem_addr, 32'h0);
        check({tag, "_wdata"}, bus.mem_wdata, 32'h0);
        check({tag, "_be"}, {28'd0, bus.mem_be}, 32'h0);
        check({tag, "_state"}, 32'(stateDbg), 32'(IDLE));
    endtask

    // One legal access; mem_ready pulses on ACCESS cycle index readyAt (never if >= TO).
    task automatic runAccess(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int readyAt, input logic [31:0] expRead,
                             input bit chkStore, input logic [3:0] expBe,
                             input logic [31:0] expWdata);
        int stalls;
        int expStalls;
        stalls    = 0;
        expStalls = (readyAt < TO) ? readyAt + 2 : TO + 1;
        MemReadM   = rd;
        MemWriteM  = wr;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wdata;
        exp_q.push_back(expRead);
        #2;
        if (StallM) stalls++;
        check({tag, "_idle_req"}, {31'd0, bus.mem_req}, 32'h0);
        check({tag, "_idle_stall"}, {31'd0, StallM}, 32'h1);
        cyc();
        for (int i = 0; i < 40 && stateDbg == ACCESS; i++) begin
            bus.mem_ready = (i == readyAt);
            bus.mem_rdata = rdata;
            #2;
            if (StallM) stalls++;
            check({tag, "_acc_req"}, {31'd0, bus.mem_req}, 32'h1);
            check({tag, "_acc_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
            check({tag, "_acc_we"}, {31'd0, bus.mem_we}, {31'd0, wr});
            if (chkStore) begin
                check({tag, "_acc_be"}, {28'd0, bus.mem_be}, {28'd0, expBe});
                check({tag, "_acc_wdata"}, bus.mem_wdata, expWdata);
            end
            cyc();
        end
        bus.mem_ready = 1'b0;
        #2;
        check({tag, "_done_state"}, 32'(stateDbg), 32'(DONE));
        check({tag, "_done_stall"}, {31'd0, StallM}, 32'h0);
        check({tag, "_done_req"}, {31'd0, bus.mem_req}, 32'h0);
        check({tag, "_done_buserr"}, {31'd0, BusErrM}, {31'd0, readyAt >= TO});
        if (exp_q.size() > 0) check({tag, "_rdata"}, ReadDataM, exp_q.pop_front());
        else check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'h1);
        check({tag, "_stalls"}, 32'(stalls), 32'(expStalls));
        cyc();
        dropOp();
        #2;
        check({tag, "_post_state"}, 32'(stateDbg), 32'(IDLE));
        check({tag, "_post_buserr"}, {31'd0, BusErrM}, 32'h0);
        check({tag, "_post_rdata"}, ReadDataM, expRead);
        cyc();
    endtask

    task automatic runFault(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr);
        MemReadM   = rd;
        MemWriteM  = wr;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = 32'h5A5A_5A5A;
        #2;
        check({tag, "_fault"}, {31'd0, FaultM}, 32'h1);
        check({tag, "_stall"}, {31'd0, StallM}, 32'h0);
        check({tag, "_req"}, {31'd0, bus.mem_req}, 32'h0);
        cyc();
        dropOp();
        #2;
        check({tag, "_fault_end"}, {31'd0, FaultM}, 32'h0);
        check({tag, "_state"}, 32'(stateDbg), 32'(IDLE));
        check({tag, "_req_after"}, {31'd0, bus.mem_req}, 32'h0);
        check({tag, "_rdata"}, ReadDataM, 32'h0);
        cyc();
    endtask

    initial begin
        reset         = 1'b1;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        dropOp();
        cyc();
        cyc();
        #2;
        checkAllZero("reset");
        cyc();
        reset = 1'b0;
        cyc();

        runAccess("lw_100",   1, 0, F3_W,  32'h100, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 0);
        runAccess("lb_103",   1, 0, F3_B,  32'h103, 0, 32'h80FF7F01, 2, 32'hFFFFFF80, 0, 0, 0);
        runAccess("lbu_103",  1, 0, F3_BU, 32'h103, 0, 32'h80FF7F01, 1, 32'h00000080, 0, 0, 0);
        runAccess("lh_102",   1, 0, F3_H,  32'h102, 0, 32'h80FF7F01, 0, 32'hFFFF80FF, 0, 0, 0);
        runAccess("lhu_100",  1, 0, F3_HU, 32'h100, 0, 32'h80FF7F01, 3, 32'h00007F01, 0, 0, 0);
        runAccess("lb_101",   1, 0, F3_B,  32'h101, 0, 32'h80FF7F01, 0, 32'h0000007F, 0, 0, 0);
        runAccess("lh_neg",   1, 0, F3_H,  32'h100, 0, 32'h00008001, 1, 32'hFFFF8001, 0, 0, 0);
        runAccess("sh_202",   0, 1, F3_H,  32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 0, 32'hFFFF8001,
                  1, 4'b1100, 32'hABCDABCD);
        runAccess("sb_301",   0, 1, F3_B,  32'h301, 32'h000000A5, 32'h0, 1, 32'hFFFF8001,
                  1, 4'b0010, 32'hA5A5A5A5);
        runAccess("sw_400",   0, 1, F3_W,  32'h400, 32'hCAFEF00D, 32'h0, 2, 32'hFFFF8001,
                  1, 4'b1111, 32'hCAFEF00D);

        // Stray completion strobe with no access pending.
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h55555555;
        #2;
        check("stray_stall", {31'd0, StallM}, 32'h0);
        cyc();
        bus.mem_ready = 1'b0;
        #2;
        check("stray_state", 32'(stateDbg), 32'(IDLE));
        check("stray_rdata", ReadDataM, 32'hFFFF8001);
        check("stray_req", {31'd0, bus.mem_req}, 32'h0);
        cyc();

        runFault("lw_101",    1, 0, F3_W,   32'h101);
        runFault("ld_f3_011", 1, 0, 3'b011, 32'h100);
        runFault("ld_f3_110", 1, 0, 3'b110, 32'h100);
        runFault("st_f3_100", 0, 1, 3'b100, 32'h100);
        runFault("rd_and_wr", 1, 1, F3_W,   32'h100);
        runFault("lh_103",    1, 0, F3_H,   32'h103);
        runFault("lhu_101",   1, 0, F3_HU,  32'h101);
        runFault("sw_102",    0, 1, F3_W,   32'h102);

        runAccess("lw_500",   1, 0, F3_W,  32'h500, 0, 32'h11223344, 0, 32'h11223344, 0, 0, 0);
        runAccess("lw_tmo",   1, 0, F3_W,  32'h504, 0, 32'h99999999, 99, 32'h00000000, 0, 0, 0);

        // Reset lands on the second ACCESS cycle; a late mem_ready must be ignored.
        MemReadM   = 1'b1;
        funct3M    = F3_W;
        ALUResultM = 32'h600;
        cyc();
        cyc();
        #1;
        check("rst_acc_state", 32'(stateDbg), 32'(ACCESS));
        check("rst_acc_req", {31'd0, bus.mem_req}, 32'h1);
        #1;
        reset = 1'b1;
        dropOp();
        #1;
        checkAllZero("rst_async");
        cyc();
        reset = 1'b0;
        cyc();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hFFFFFFFF;
        cyc();
        bus.mem_ready = 1'b0;
        #2;
        checkAllZero("rst_late_ready");
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum ACCESS cycles before a bus error is declared.
REQ-002 clk  in  1  pipeline clock, rising-edge active.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 MemReadM  in  1  MEM-stage instruction is a load.
REQ-005 MemWriteM  in  1  MEM-stage instruction is a store.
REQ-006 funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 ALUResultM  in  32  effective byte address.
REQ-008 WriteDataM  in  32  store data, right-aligned.
REQ-009 ReadDataM  out  32  extended load result, consumed by the MEM/WB register.
REQ-010 StallM  out  1  freeze IF..MEM stages and hold MEM/WB input.
REQ-011 FaultM  out  1  one-cycle pulse: misaligned address or illegal funct3/op.
REQ-012 BusErrM  out  1  one-cycle pulse: memory timeout.
REQ-013 mem_req  out  1  bus request, registered.
REQ-014 mem_we  out  1  1 = write, 0 = read.
REQ-015 mem_addr  out  32  word address: ALUResultM with [1:0] forced to 00.
REQ-016 mem_wdata, mem_be  out  32, 4  lane-aligned store data and byte enables.
REQ-017 mem_ready  in  1  responder completion strobe, one cycle.
REQ-018 mem_rdata  in  32  read word, valid when mem_ready=1.

Function
REQ-019 FSM states: IDLE, ACCESS, DONE.
REQ-020 IDLE, op valid (exactly one of MemReadM/MemWriteM, legal funct3, aligned address): StallM=1 combinationally; next state ACCESS with mem_req=1; mem_we, mem_addr, mem_wdata and mem_be registered.
REQ-021 ACCESS: mem_req and the bus fields are held stable and StallM=1 until mem_ready=1; on that edge mem_req drops, a load captures its extended data, and the next state is DONE.
REQ-022 DONE: StallM=0 for exactly one cycle while the same instruction is still at MEM; no re-issue; next state IDLE.
REQ-023 Minimum latency with mem_ready on the first ACCESS cycle: 3 cycles (IDLE, ACCESS, DONE), of which 2 are stalled.
REQ-024 Loads: byte lane = addr[1:0], half lane = addr[1]; B/H sign-extend; BU/HU zero-extend; W passes through.
REQ-025 Stores: SB gives be = 0001 << addr[1:0] with the byte replicated on all four lanes; SH gives be = 0011 or 1100 with the half replicated; SW gives be = 1111.
REQ-026 Misalignment: H with addr[0]=1; W with addr[1:0]!=00.
REQ-027 Fault (misaligned access, funct3 of 011/110/111, store funct3 >=011, or MemReadM and MemWriteM both set): no bus access, FaultM=1 for one cycle, ReadDataM=0, StallM=0, FSM stays in IDLE.
REQ-028 Timeout: a counter clears on ACCESS entry; on reaching TIMEOUT_CYCLES with no mem_ready, mem_req drops, the FSM enters DONE, BusErrM pulses for that DONE cycle, and ReadDataM=0.
REQ-029 mem_ready outside ACCESS is ignored.
REQ-030 ReadDataM is registered; it changes only on load capture or fault and otherwise holds.
REQ-031 Neither MemReadM nor MemWriteM set: StallM=0 and no state change.
REQ-032 Store completion leaves ReadDataM unchanged.

Reset
REQ-033 On reset the FSM is IDLE, the counter is 0, and every output is 0 (ReadDataM, StallM, FaultM, BusErrM, mem_req, mem_we, mem_addr, mem_wdata, mem_be).
REQ-034 Reset mid-ACCESS drops mem_req asynchronously; the pending access is abandoned and a late mem_ready is ignored.

Structure
REQ-035 A shared package holds the funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU), the FSM state encoding, and the TIMEOUT_CYCLES default.
REQ-036 A combinational sub-module lsu_align contains the store lane/byte-enable generation and the load extraction/extension.

Verification
REQ-037 LW at 0x100, mem_ready on the first ACCESS cycle with rdata 0xDEADBEEF -> StallM high for 2 cycles, then ReadDataM=0xDEADBEEF in DONE.
REQ-038 LB and LBU at 0x103 with rdata 0x80FF7F01 -> ReadDataM=0xFFFFFF80 for LB and 0x00000080 for LBU.
REQ-039 SH at 0x202 with WriteDataM 0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x200, mem_we=1.
REQ-040 LW at 0x101 -> FaultM pulses, no mem_req, StallM=0, ReadDataM=0.
REQ-041 TIMEOUT_CYCLES=4 and mem_ready held low -> mem_req drops after 4 ACCESS cycles, BusErrM pulses, FSM returns to IDLE.
REQ-042 Reset asserted on the 2nd ACCESS cycle, then mem_ready pulses after reset -> all outputs 0, FSM IDLE, ReadDataM unchanged from 0.
